// File: rtl/axi_fabric_0_pkg.sv
// Shared AXI fabric 0 types: arbiter state encoding and master index helpers.
// Pure declarations. No latency and no backpressure.
package axi_fabric_0_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam int MST_MAX = 16;

    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int MST_IDX_W      = idx_width(MST_MAX);
    localparam int ARB_IDX_W_DFLT = idx_width(2);

    typedef logic [MST_IDX_W-1:0] mst_idx_t;

endpackage

// File: rtl/axi_rr_pick_0.sv
// Combinational picker: first requester at or above base, else lowest requester (wrap).
// Zero latency. No backpressure; any=0 when nothing requests.
module axi_rr_pick_0 #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic [N-1:0] gnt_oh,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any && req[j] && (j >= int'(base))) begin
                any       = 1'b1;
                gnt_oh[j] = 1'b1;
                gnt_idx   = W'(j);
            end
        end
        // Wrapped half of the search: indices below base.
        for (int j = 0; j < N; j++) begin
            if (!any && req[j]) begin
                any       = 1'b1;
                gnt_oh[j] = 1'b1;
                gnt_idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/axi_wr_arb_0.sv
// Per-slave AXI write arbiter: 1-cycle arbitration, grant held through AW, W(last) and B.
// Handshakes pass straight through for the granted master only. AXI_WR_ARB_RR_EN selects round-robin over fixed priority.
module axi_wr_arb_0
    import axi_fabric_0_pkg::*;
#(
    parameter int                     PARAM_WIDTH    = 32,
    parameter logic [PARAM_WIDTH-1:0] MASTER_NUM     = 2,
    parameter logic [PARAM_WIDTH-1:0] MASTER_NUM_LOG = ARB_IDX_W_DFLT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MASTER_NUM-1:0]     m_awvalid,
    output logic [MASTER_NUM-1:0]     m_awready,
    input  logic [MASTER_NUM-1:0]     m_wvalid,
    input  logic [MASTER_NUM-1:0]     m_wlast,
    output logic [MASTER_NUM-1:0]     m_wready,
    output logic [MASTER_NUM-1:0]     m_bvalid,
    input  logic [MASTER_NUM-1:0]     m_bready,
    output logic                      s_awvalid,
    input  logic                      s_awready,
    output logic                      s_wvalid,
    output logic                      s_wlast,
    input  logic                      s_wready,
    input  logic                      s_bvalid,
    output logic                      s_bready,
    output logic [MASTER_NUM_LOG-1:0] grant_id,
    output logic                      busy
);

    localparam int N = int'(MASTER_NUM);
    localparam int L = int'(MASTER_NUM_LOG);

    arb_state_t      state, state_nxt;
    logic [L-1:0]    base;
    logic [L-1:0]    pick_idx;
    logic [N-1:0]    pick_oh;
    logic            any_req;
    logic            b_done;

    axi_rr_pick_0 #(
        .N (N),
        .W (L)
    ) u_pick (
        .req     (m_awvalid),
        .base    (base),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (any_req)
    );

    assign b_done = (state == RESP) && s_bvalid && m_bready[grant_id];

`ifdef AXI_WR_ARB_RR_EN
    logic [L-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (b_done) begin
            rr_ptr <= (grant_id == L'(MASTER_NUM - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    assign base = rr_ptr;
`else
    assign base = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && any_req) begin
                grant_id <= pick_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        s_bready  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_req) state_nxt = ADDR;
            end
            ADDR: begin
                s_awvalid           = m_awvalid[grant_id];
                m_awready[grant_id] = s_awready;
                // A request withdrawn before its handshake releases the slave.
                if (m_awvalid[grant_id] && s_awready) begin
                    state_nxt = DATA;
                end else if (!m_awvalid[grant_id]) begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                s_wvalid           = m_wvalid[grant_id];
                s_wlast            = m_wlast[grant_id];
                m_wready[grant_id] = s_wready;
                if (m_wvalid[grant_id] && s_wready && m_wlast[grant_id]) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                m_bvalid[grant_id] = s_bvalid;
                s_bready           = m_bready[grant_id];
                if (b_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_wr_arb_0.sv
// Bench for axi_wr_arb_0 (3 masters): directed scenarios plus random traffic against a transaction-level model.
// Honours AXI_WR_ARB_RR_EN in the model to match the build.
module tb_axi_wr_arb_0;
    import axi_fabric_0_pkg::*;

    localparam int N = 3;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] m_awvalid = '0, m_awready, m_wvalid = '0, m_wlast = '0;
    logic [N-1:0] m_wready, m_bvalid, m_bready = '0;
    logic         s_awvalid, s_awready = 1'b0, s_wvalid, s_wlast, s_wready = 1'b0;
    logic         s_bvalid = 1'b0, s_bready, busy;
    logic [L-1:0] grant_id;

    always #5 clk = ~clk;

    axi_wr_arb_0 #(
        .PARAM_WIDTH    (32),
        .MASTER_NUM     (N),
        .MASTER_NUM_LOG (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wvalid  (m_wvalid),
        .m_wlast   (m_wlast),
        .m_wready  (m_wready),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wvalid  (s_wvalid),
        .s_wlast   (s_wlast),
        .s_wready  (s_wready),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the slave and which phase it is waiting on.
    bit       m_known = 1'b0;
    int       m_phase = 0;     // 0 free, 1 awaiting address, 2 streaming data, 3 awaiting response
    int       m_owner = 0;
    int       m_ptr   = 0;
    mst_idx_t hist[$];
    int       busy_cnt = 0, wr1_cnt = 0;
    logic     obs_busy;
    logic [L-1:0] obs_gid;

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    function automatic int model_pick(input logic [N-1:0] req);
`ifdef AXI_WR_ARB_RR_EN
        for (int k = 0; k < N; k++) if (bit_at(req, (m_ptr + k) % N)) return (m_ptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (bit_at(req, k)) return k;
`endif
        return 0;
    endfunction

    task automatic step(input bit r, input logic [N-1:0] awv, input logic [N-1:0] wv,
                        input logic [N-1:0] wl, input logic [N-1:0] br,
                        input bit awr, input bit wr, input bit bv);
        logic [N-1:0] e_awr, e_wr, e_bv;
        logic         e_saw, e_sw, e_sl, e_sb;
        rst = r; m_awvalid = awv; m_wvalid = wv; m_wlast = wl; m_bready = br;
        s_awready = awr; s_wready = wr; s_bvalid = bv;
        @(negedge clk);
        e_awr = '0; e_wr = '0; e_bv = '0; e_saw = 0; e_sw = 0; e_sl = 0; e_sb = 0;
        case (m_phase)
            1: begin e_saw = bit_at(awv, m_owner); e_awr = awr ? (N'(1) << m_owner) : '0; end
            2: begin e_sw = bit_at(wv, m_owner); e_sl = bit_at(wl, m_owner);
                     e_wr = wr ? (N'(1) << m_owner) : '0; end
            3: begin e_bv = bv ? (N'(1) << m_owner) : '0; e_sb = bit_at(br, m_owner); end
            default: ;
        endcase
        if (m_known) begin
            check_eq("outputs",
                     32'({m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_wlast, s_bready, busy}),
                     32'({e_awr, e_wr, e_bv, e_saw, e_sw, e_sl, e_sb, m_phase != 0}));
            check_eq("grant_id", 32'(grant_id), 32'(m_owner));
        end
        obs_busy = busy; obs_gid = grant_id;
        if (busy) busy_cnt++;
        if (m_wready[1]) wr1_cnt++;
        if (r) begin
            m_known = 1'b1; m_phase = 0; m_owner = 0; m_ptr = 0;
        end else if (m_known) begin
            case (m_phase)
                0: if (awv != '0) begin
                       m_owner = model_pick(awv); m_phase = 1; hist.push_back(mst_idx_t'(m_owner));
                   end
                1: if (!bit_at(awv, m_owner)) m_phase = 0;
                   else if (awr) m_phase = 2;
                2: if (bit_at(wv, m_owner) && wr && bit_at(wl, m_owner)) m_phase = 3;
                3: if (bv && bit_at(br, m_owner)) begin
                       m_phase = 0; m_ptr = (m_owner + 1) % N;
                   end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1, '0, '0, '0, '0, 0, 0, 0);
        step(1, '0, '0, '0, '0, 0, 0, 0);
        hist.delete();
        busy_cnt = 0;
        wr1_cnt  = 0;
    endtask

    task automatic check_hist(input string tag, input int e0, input int e1, input int e2, input int e3, input int cnt);
        int e[4];
        e = '{e0, e1, e2, e3};
        check_eq({tag, "_count"}, 32'(hist.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < hist.size(); i++)
            check_eq({tag, "_grant"}, 32'(hist[i]), 32'(e[i]));
    endtask

    initial begin
        int beat;
        bit wrt;

        // Single master, all handshakes immediate.
        do_reset();
        check_eq("reset_busy", 32'(obs_busy), 32'(0));
        for (int c = 0; c < 4; c++) step(0, 3'b001, 3'b001, 3'b001, 3'b001, 1, 1, 1);
        step(0, '0, '0, '0, '0, 0, 0, 0);
        check_eq("single_busy_cycles", 32'(busy_cnt), 32'(3));
        check_hist("single", 0, 0, 0, 0, 1);

        // Two-master contention for four transactions.
        do_reset();
        for (int c = 0; c < 16; c++) step(0, 3'b011, 3'b011, 3'b011, 3'b011, 1, 1, 1);
`ifdef AXI_WR_ARB_RR_EN
        check_hist("contend2", 0, 1, 0, 1, 4);
`else
        check_hist("contend2", 0, 0, 0, 0, 4);
`endif

        // Three-master contention: pointer wraps 2 -> 0.
        do_reset();
        for (int c = 0; c < 16; c++) step(0, 3'b111, 3'b111, 3'b111, 3'b111, 1, 1, 1);
`ifdef AXI_WR_ARB_RR_EN
        check_hist("contend3", 0, 1, 2, 0, 4);
`else
        check_hist("contend3", 0, 0, 0, 0, 4);
`endif

        // Back-pressure on every channel.
        do_reset();
        step(0, 3'b011, 3'b011, 3'b000, 3'b011, 0, 0, 0);
        for (int c = 0; c < 3; c++) step(0, 3'b011, 3'b011, 3'b000, 3'b011, 0, 0, 0);
        step(0, 3'b011, 3'b011, 3'b000, 3'b011, 1, 0, 0);
        beat = 0;
        for (int c = 0; c < 20 && beat < 4; c++) begin
            wrt = (c % 2) == 1;
            step(0, 3'b011, 3'b011, (beat == 3) ? 3'b001 : 3'b000, 3'b011, 0, wrt, 0);
            if (wrt) beat++;
        end
        for (int c = 0; c < 5; c++) step(0, 3'b011, 3'b011, 3'b000, 3'b011, 0, 0, 0);
        step(0, 3'b011, 3'b011, 3'b000, 3'b011, 0, 0, 1);
        check_eq("bp_busy_cycles", 32'(busy_cnt), 32'(18));
        check_eq("bp_wready1_quiet", 32'(wr1_cnt), 32'(0));
        check_hist("bp", 0, 0, 0, 0, 1);

        // Reset in the middle of a burst.
        do_reset();
        step(0, 3'b001, 3'b001, 3'b000, 3'b001, 0, 1, 0);
        step(0, 3'b001, 3'b001, 3'b000, 3'b001, 1, 1, 0);
        step(0, 3'b001, 3'b001, 3'b000, 3'b001, 0, 1, 0);
        step(0, 3'b001, 3'b001, 3'b000, 3'b001, 0, 1, 0);
        hist.delete();
        step(1, 3'b010, 3'b010, 3'b000, 3'b010, 0, 1, 0);
        step(0, 3'b010, 3'b010, 3'b000, 3'b010, 0, 1, 0);
        check_eq("rst_mid_busy", 32'(obs_busy), 32'(0));
        check_eq("rst_mid_gid", 32'(obs_gid), 32'(0));
        step(0, 3'b010, 3'b010, 3'b000, 3'b010, 0, 1, 0);
        check_eq("rst_regrant_busy", 32'(obs_busy), 32'(1));
        check_eq("rst_regrant_gid", 32'(obs_gid), 32'(1));

        // Request withdrawn in ADDR; the other master is granted after one IDLE cycle.
        do_reset();
        step(0, 3'b011, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        step(0, 3'b010, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        step(0, 3'b010, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        step(0, 3'b010, 3'b000, 3'b000, 3'b000, 0, 0, 0);
        check_eq("drop_gid", 32'(obs_gid), 32'(1));
        check_hist("drop", 0, 1, 0, 0, 2);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 199) == 0,
                 N'($urandom_range(0, 7)), N'($urandom_range(0, 7)), N'($urandom_range(0, 7)),
                 N'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wr_arb_0.md
Name: axi_wr_arb_0

Overview:
- Per-slave write-channel arbiter for AXI fabric 0.
- One instance sits in front of each slave port, downstream of the fabric address decoder.
- Master AW requests arrive already qualified by the decoder's select bit for this slave.
- Grants one master at a time and holds the grant until AW, W (through WLAST) and B have completed, then rearbitrates.
- Drives grant_id to the fabric's AW/W/B datapath muxes.

Parameters:
- PARAM_WIDTH, 32, width of the parameter declarations.
- MASTER_NUM, 2, number of requesting masters (2..16).
- MASTER_NUM_LOG, 1, clog2(MASTER_NUM), width of grant_id.

Ports:
- clk  in  1  fabric clock.
- rst  in  1  synchronous, active-high reset.
- m_awvalid  in  MASTER_NUM  per-master AWVALID ANDed with the decoder select for this slave.
- m_awready  out  MASTER_NUM  per-master AWREADY.
- m_wvalid  in  MASTER_NUM  per-master WVALID.
- m_wlast  in  MASTER_NUM  per-master WLAST.
- m_wready  out  MASTER_NUM  per-master WREADY.
- m_bvalid  out  MASTER_NUM  per-master BVALID.
- m_bready  in  MASTER_NUM  per-master BREADY.
- s_awvalid  out  1  slave AWVALID.
- s_awready  in  1  slave AWREADY.
- s_wvalid  out  1  slave WVALID.
- s_wlast  out  1  slave WLAST.
- s_wready  in  1  slave WREADY.
- s_bvalid  in  1  slave BVALID.
- s_bready  out  1  slave BREADY.
- grant_id  out  MASTER_NUM_LOG  index of the granted master; datapath mux select.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: the clock is clk, the reset is rst.
  - On rst: state=IDLE, grant_id=0, busy=0, RR pointer=0.
  - All handshake outputs are combinational from state and are 0 in IDLE. They are therefore 0 in the cycle after rst.
  - rst asserted mid-transaction forces IDLE on the next edge regardless of state.
- States and transitions:
  - IDLE: if |m_awvalid, pick winner g, register grant_id=g, go to ADDR. Arbitration latency is 1 cycle. No outputs are asserted in IDLE.
  - ADDR:
    - s_awvalid=m_awvalid[g]; m_awready[g]=s_awready; m_awready[others]=0.
    - On m_awvalid[g]&s_awready, go to DATA.
    - If m_awvalid[g] drops before the handshake (protocol violation or decoder change), return to IDLE without a handshake.
  - DATA:
    - s_wvalid=m_wvalid[g]; s_wlast=m_wlast[g]; m_wready[g]=s_wready.
    - On s_wvalid&s_wready&s_wlast, go to RESP.
    - Data beats before the AW handshake are back-pressured: m_wready=0 outside DATA.
  - RESP:
    - m_bvalid[g]=s_bvalid; s_bready=m_bready[g].
    - On s_bvalid&m_bready[g], go to IDLE and update the priority state.
- Timing rules:
  - Minimum transaction length is 4 cycles (IDLE→ADDR→DATA→RESP→IDLE).
  - There is exactly one IDLE cycle between consecutive grants.
- Isolation:
  - Non-granted masters see all ready/valid outputs at 0 at all times.
  - grant_id is stable from ADDR entry until the next IDLE→ADDR transition.
- Simultaneous events:
  - Requests from several masters in the same IDLE cycle are resolved by the priority rule; losers keep waiting.
  - An AW handshake and a W beat in the same cycle cannot occur, because W is gated until DATA.
- Width rule: the pointer increment wraps modulo MASTER_NUM, including non-power-of-2 MASTER_NUM.

Optional Feature:
- Macro: AXI_WR_ARB_RR_EN.
- Defined (round-robin):
  - The search starts at the RR pointer and wraps.
  - On B handshake, pointer=(g+1) mod MASTER_NUM.
  - A master requesting continuously is serviced at least once every MASTER_NUM transactions.
- Undefined (fixed priority):
  - The lowest requesting index always wins.
  - The pointer register is not implemented.

Decomposition:
- Shared package axi_fabric_0_pkg:
  - state enum (IDLE, ADDR, DATA, RESP), 2-bit encoding.
  - MASTER_NUM_LOG helper constant.
  - Master index typedef.
- Sub-module axi_rr_pick_0:
  - Combinational picker: req vector plus base index in; one-hot and index out.
  - base is tied to 0 when AXI_WR_ARB_RR_EN is undefined.

Test Plan:
- Single master: m_awvalid=2'b01, s_awready=1, one beat with wlast=1, s_wready=1, s_bvalid=1, m_bready=1 → grant_id=0; ADDR, DATA and RESP each last 1 cycle; busy high 3 cycles; idle after.
- Contention: m_awvalid=2'b11 held for 4 transactions →
  - with RR: grant sequence 0,1,0,1.
  - without RR: 0,0,0,0.
- Back-pressure: s_awready low 3 cycles, then a 4-beat burst with s_wready toggling, then s_bvalid delayed 5 cycles → no state advance until each handshake; m_wready[1]=0 throughout; s_wlast only on beat 4.
- Reset mid-op: rst asserted in DATA after beat 2 → next cycle state=IDLE, all outputs 0, grant_id=0, busy=0; new request granted 1 cycle after rst deasserts.
- Request drop: m_awvalid[g] deasserts in ADDR before s_awready → return to IDLE; no m_awready pulse; other master granted next cycle if requesting.
- MASTER_NUM=3 with RR: all three request continuously → grants 0,1,2,0; pointer wraps from 2 to 0.
